uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small write FIFO in front of it.
// Frames are start, LSB-first data, optional parity, then stop bits, sent back-to-back while data is queued.
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_W-1:0]              div,
  input  logic                          we,
  input  logic [7:0]                    din,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overrun,
  output logic                          tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned BW = 3;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t                r_state;
  logic [DATA_BITS-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wp;
  logic [AW-1:0]         r_rp;
  logic [LW-1:0]         r_level;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_overrun;
  logic                  r_tx;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_par;
  logic [DIV_W-1:0]      r_div;
  logic [DIV_W-1:0]      r_cnt;
  logic [BW-1:0]         r_bit;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_bit_end;
  logic                  w_frame_end;
  logic                  w_idle_nxt;
  logic [LW-1:0]         w_level_nxt;
  logic [DATA_BITS-1:0]  w_rd;
  logic [DIV_W-1:0]      w_div_eff;

  // Full is judged on pre-edge occupancy, so a same-cycle pop never rescues a write.
  always_comb begin
    w_push      = we && !r_full;
    w_bit_end   = (r_cnt == r_div - DIV_W'(1));
    w_frame_end = (r_state == S_STOP) && w_bit_end && (r_bit == BW'(STOP_BITS - 1));
    w_pop       = (r_level != '0) && ((r_state == S_IDLE) || w_frame_end);
    w_idle_nxt  = !w_pop && ((r_state == S_IDLE) || w_frame_end);
    w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
    w_rd        = r_mem[r_rp];
    w_div_eff   = (div < DIV_W'(2)) ? DIV_W'(2) : div;
  end

  // Storage array is not reset; the pointers alone define its valid contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= din[DATA_BITS-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wp      <= '0;
      r_rp      <= '0;
      r_level   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_overrun <= 1'b0;
      r_tx      <= 1'b1;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_div     <= '0;
      r_cnt     <= '0;
      r_bit     <= '0;
    end else begin
      r_level   <= w_level_nxt;
      r_full    <= (w_level_nxt == LW'(FIFO_DEPTH));
      r_empty   <= (w_level_nxt == '0) && w_idle_nxt;
      r_overrun <= we && r_full;
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);

      if (w_pop) begin
        // Load the next frame, either from idle or straight out of the last stop bit.
        r_state <= S_START;
        r_shift <= w_rd;
        r_par   <= (^w_rd) ^ (PARITY == 1);
        r_div   <= w_div_eff;
        r_cnt   <= '0;
        r_bit   <= '0;
        r_tx    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: r_tx <= 1'b1;
          S_START: begin
            if (w_bit_end) begin
              r_cnt   <= '0;
              r_state <= S_DATA;
              r_tx    <= r_shift[0];
            end else r_cnt <= r_cnt + DIV_W'(1);
          end
          S_DATA: begin
            if (w_bit_end) begin
              r_cnt <= '0;
              if (r_bit == BW'(DATA_BITS - 1)) begin
                r_bit <= '0;
                if (PARITY != 0) begin
                  r_state <= S_PAR;
                  r_tx    <= r_par;
                end else begin
                  r_state <= S_STOP;
                  r_tx    <= 1'b1;
                end
              end else begin
                r_bit   <= r_bit + BW'(1);
                r_shift <= r_shift >> 1;
                r_tx    <= r_shift[1];
              end
            end else r_cnt <= r_cnt + DIV_W'(1);
          end
          S_PAR: begin
            if (w_bit_end) begin
              r_cnt   <= '0;
              r_bit   <= '0;
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else r_cnt <= r_cnt + DIV_W'(1);
          end
          S_STOP: begin
            if (w_bit_end) begin
              r_cnt <= '0;
              if (w_frame_end) begin
                r_state <= S_IDLE;
                r_bit   <= '0;
              end else r_bit <= r_bit + BW'(1);
              r_tx <= 1'b1;
            end else r_cnt <= r_cnt + DIV_W'(1);
          end
          default: begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign full    = r_full;
  assign empty   = r_empty;
  assign level   = r_level;
  assign overrun = r_overrun;
  assign tx      = r_tx;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three framing variants share one stimulus stream and are
// compared every cycle against a waveform-level model, plus literal frame checks.
module tb_uart_tx_fifo;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [15:0]     div = 16'd4;
  logic            we = 1'b0;
  logic [7:0]      din = 8'd0;
  logic [2:0]      o_full, o_empty, o_ovr, o_tx;
  logic [2:0][2:0] o_lvl;

  int ntests = 0;
  int nfail  = 0;
  int busy   = 0;
  bit busy_en = 1'b0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4), .DIV_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .div(div), .we(we), .din(din), .full(o_full[0]),
    .empty(o_empty[0]), .level(o_lvl[0]), .overrun(o_ovr[0]), .tx(o_tx[0]));
  uart_tx_fifo #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4), .DIV_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .div(div), .we(we), .din(din), .full(o_full[1]),
    .empty(o_empty[1]), .level(o_lvl[1]), .overrun(o_ovr[1]), .tx(o_tx[1]));
  uart_tx_fifo #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4), .DIV_W(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .div(div), .we(we), .din(din), .full(o_full[2]),
    .empty(o_empty[2]), .level(o_lvl[2]), .overrun(o_ovr[2]), .tx(o_tx[2]));

  function automatic int cfg_db(input int i);
    return (i == 0) ? 8 : 7;
  endfunction
  function automatic int cfg_par(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 2 : 1);
  endfunction
  function automatic int cfg_sb(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  task automatic chk(input string name, input int i, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d", name, i, $time, act, exp);
    end
  endtask

  // Model: a queue per instance plus the expected bit sequence of the frame on the line.
  int mq    [3][16];
  int mhead [3];
  int mcnt  [3];
  bit mact  [3];
  bit movr  [3];
  bit fb    [3][16];
  int nbits [3];
  int fdiv  [3];
  int fpos  [3];

  task automatic model_step(input int i);
    int  cpre, d, ones, k, db;
    bit  start;
    cpre  = mcnt[i];
    start = 1'b0;
    if (!mact[i]) start = (cpre > 0);
    else begin
      fpos[i]++;
      if (fpos[i] == nbits[i] * fdiv[i]) begin
        mact[i] = 1'b0;
        start   = (cpre > 0);
      end
    end
    db = cfg_db(i);
    if (start) begin
      d        = mq[i][mhead[i]];
      mhead[i] = (mhead[i] + 1) % 16;
      mcnt[i]--;
      k = 0; ones = 0;
      fb[i][k++] = 1'b0;
      for (int j = 0; j < db; j++) begin
        fb[i][k++] = bit'((d >> j) & 1);
        ones += (d >> j) & 1;
      end
      if (cfg_par(i) == 2) fb[i][k++] = bit'(ones % 2);
      else if (cfg_par(i) == 1) fb[i][k++] = bit'((ones % 2) == 0);
      for (int s = 0; s < cfg_sb(i); s++) fb[i][k++] = 1'b1;
      nbits[i] = k;
      fdiv[i]  = (int'(div) < 2) ? 2 : int'(div);
      fpos[i]  = 0;
      mact[i]  = 1'b1;
    end
    if (we && cpre < 4) begin
      mq[i][(mhead[i] + mcnt[i]) % 16] = int'(din) & ((1 << db) - 1);
      mcnt[i]++;
    end
    movr[i] = we && (cpre == 4);
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        mhead[i] = 0; mcnt[i] = 0; mact[i] = 1'b0; movr[i] = 1'b0; fpos[i] = 0;
      end else model_step(i);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int etx;
      etx = mact[i] ? int'(fb[i][fpos[i] / fdiv[i]]) : 1;
      chk("tx", i, int'(o_tx[i]), etx);
      chk("level", i, int'(o_lvl[i]), mcnt[i]);
      chk("full", i, int'(o_full[i]), int'(mcnt[i] == 4));
      chk("empty", i, int'(o_empty[i]), int'(mcnt[i] == 0 && !mact[i]));
      chk("overrun", i, int'(o_ovr[i]), int'(movr[i]));
    end
    if (busy_en && !o_empty[0]) busy++;
  end

  task automatic write_byte(input logic [7:0] b);
    we = 1'b1; din = b;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_empty != 3'b111 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 0, int'(o_empty), 7);
  endtask

  initial begin
    int pat_a [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int rate;

    repeat (3) @(negedge clk);
    chk("rst_tx", 0, int'(o_tx), 7);
    chk("rst_empty", 0, int'(o_empty), 7);
    chk("rst_full", 0, int'(o_full), 0);
    chk("rst_level", 0, int'(o_lvl[0]), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 0xA5, 8N1, divisor 4
    div = 16'd4;
    write_byte(8'hA5);
    chk("lat_tx_idle", 0, int'(o_tx[0]), 1);
    chk("lat_level", 0, int'(o_lvl[0]), 1);
    chk("lat_empty", 0, int'(o_empty[0]), 0);
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (c < 40) chk("a5_tx", c, int'(o_tx[0]), pat_a[c / 4]);
      if (c == 39) chk("a5_busy", 0, int'(o_empty[0]), 0);
      if (c == 40) chk("a5_empty", 0, int'(o_empty[0]), 1);
    end
    wait_idle();

    // 0x03 with 7-bit even (inst 1) and odd (inst 2) parity, divisor 2
    div = 16'd2;
    write_byte(8'h03);
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      if (c == 16) begin
        chk("par_even", 1, int'(o_tx[1]), 0);
        chk("par_odd", 2, int'(o_tx[2]), 1);
      end
      if (c == 19) chk("odd_busy", 2, int'(o_empty[2]), 0);
      if (c == 20) chk("odd_len20", 2, int'(o_empty[2]), 1);
    end
    wait_idle();

    // Burst of five writes behind an active frame
    div = 16'd4;
    busy = 0; busy_en = 1'b1;
    write_byte(8'h11);
    repeat (2) @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      we = 1'b1; din = 8'(8'h20 + j);
      @(negedge clk);
      if (j == 3) chk("full_after4", 0, int'(o_full), 7);
      if (j == 4) begin
        chk("ovr_pulse", 0, int'(o_ovr), 7);
        chk("level4", 0, int'(o_lvl[0]), 4);
      end
    end
    we = 1'b0;
    @(negedge clk);
    chk("ovr_one_cycle", 0, int'(o_ovr), 0);
    wait_idle();
    busy_en = 1'b0;
    chk("b2b_busy", 0, busy, 201);

    // Divisor 0 and 1 both clamp to 2 cycles per bit
    for (int p = 0; p < 2; p++) begin
      div = 16'(p);
      write_byte(8'h01);
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        chk("div_clamp", p, int'(o_tx[0]), int'(c >= 2 && c < 4));
      end
      wait_idle();
    end

    // Divisor changed mid-frame only affects the next frame
    div = 16'd4;
    busy = 0; busy_en = 1'b1;
    write_byte(8'h55);
    repeat (10) @(negedge clk);
    div = 16'd8;
    write_byte(8'h0F);
    wait_idle();
    busy_en = 1'b0;
    chk("div_latch", 0, busy, 121);

    // Reset in the middle of a data bit with two entries queued
    div = 16'd4;
    write_byte(8'h3C);
    we = 1'b1; din = 8'hC3;
    @(negedge clk);
    din = 8'h5A;
    @(negedge clk);
    we = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_level", 0, int'(o_lvl[0]), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_tx", 0, int'(o_tx), 7);
    chk("rst_async_level", 0, int'(o_lvl[0]), 0);
    chk("rst_async_empty", 0, int'(o_empty), 7);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      chk("no_frame_after_rst", 0, int'(o_tx[0]), 1);
    end

    // Randomized traffic with alternating write pressure and divisor changes
    rate = 40;
    for (int n = 0; n < 4000; n++) begin
      if (n % 500 == 0) rate = (rate == 40) ? 2 : 40;
      we  = ($urandom_range(0, 99) < rate);
      din = 8'($urandom);
      if ($urandom_range(0, 199) == 0) div = 16'($urandom_range(0, 5));
      if (n == 2500) begin
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else @(negedge clk);
    end
    we = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
